// File: rtl/divider_16bit_seq_pkg.sv
// rtl/divider_16bit_seq_pkg.sv - shared types and constants for the sequential divider
//
// Purpose : state encoding, default operand width and the divide-by-zero
//           quotient pattern shared by the divider top and its step unit.
// Ports   : none (package).

package divider_16bit_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Quotient reported when the divisor is zero.
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_16bit_seq_step_sub.sv
// rtl/divider_16bit_seq_step_sub.sv - combinational trial subtract for one restoring step
//
// Purpose : computes diff = rs - {0, divisor} as a WIDTH+1-bit two's-complement
//           add (inverted divisor plus carry-in of one). ge is set when the
//           result is non-negative, i.e. the divisor fits into rs.
// Ports   : rs_i      [WIDTH:0]   shifted partial remainder
//           divisor_i [WIDTH-1:0] divisor
//           diff_o    [WIDTH:0]   rs_i - divisor_i
//           ge_o                  rs_i >= divisor_i

module div_step_sub
    import divider_16bit_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rs_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   diff_o,
    output logic             ge_o
);

    logic [WIDTH:0] subtrahend_n;

    assign subtrahend_n = ~{1'b0, divisor_i};
    assign diff_o       = rs_i + subtrahend_n + {{WIDTH{1'b0}}, 1'b1};
    assign ge_o         = ~diff_o[WIDTH];

endmodule

// File: rtl/divider_16bit_seq.sv
// rtl/divider_16bit_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
//
// Purpose : accepts a dividend/divisor pair on start while not busy, then
//           produces one quotient bit per clock for WIDTH clocks. done pulses
//           for one cycle with the result; results hold until the next
//           completion or reset. A zero divisor completes immediately with
//           an all-ones quotient, remainder = dividend and div_by_zero set.
// Ports   : clk         system clock, rising edge
//           rst         asynchronous active-high reset
//           start       request, sampled only when busy is low
//           dividend    numerator, captured on the accepting edge
//           divisor     denominator, captured on the accepting edge
//           busy        high while iterating
//           done        one-cycle completion pulse
//           quotient    result quotient
//           remainder   result remainder
//           div_by_zero last completed operation had a zero divisor

module divider_16bit_seq
    import divider_16bit_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] q_q;
    // The partial remainder is always below the divisor between steps, so its
    // WIDTH+1-th bit is always zero and only WIDTH bits are stored.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    assign rs = {1'b0, r_q, q_q[WIDTH-1]};

    div_step_sub #(
        .WIDTH (WIDTH)
    ) u_step (
        .rs_i      (rs),
        .divisor_i (divisor_q),
        .diff_o    (diff),
        .ge_o      (ge)
    );

    // Restoring step: keep the difference when the divisor fit, else keep the
    // shifted remainder. The sign of diff selects; ge becomes the quotient bit.
    assign r_d = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_d = {q_q[WIDTH-2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            q_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    // DONE also accepts, giving back-to-back operation.
                    if (start) begin
                        divisor_q <= divisor;
                        q_q       <= dividend;
                        r_q       <= '0;
                        count_q   <= '0;
                        dbz_q     <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= ALL_ONES;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_16bit_seq.sv
// tb/tb_divider_16bit_seq.sv - self-checking bench for divider_16bit_seq

module tb_divider_16bit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

    divider_16bit_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives a request and returns just after the accept edge.
    task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts accept-relative edges until done is seen at a negedge.
    // Returns lat=-1 if done never arrives; busy_ok clears if busy is low
    // on any intermediate cycle or high in the done cycle.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
        end
    endtask

    // Checks the one-cycle done pulse and that results hold afterwards.
    task automatic check_pulse(input logic [15:0] q, input logic [15:0] r);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("q_held", {16'd0, quotient}, {16'd0, q});
        check("r_held", {16'd0, remainder}, {16'd0, r});
    endtask

    int   lat;
    logic busy_ok;
    logic [15:0] rd, rs, eq, er;

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{16'd100,   16'd7,      16'd14,    16'd2,   1'b0, 16};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,   1'b0, 16};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,   1'b0, 16};
        vecs[3] = '{16'd3,     16'd10,     16'd0,     16'd3,   1'b0, 16};
        vecs[4] = '{16'd0,     16'd5,      16'd0,     16'd0,   1'b0, 16};
        vecs[5] = '{16'd5,     16'd0,      16'hFFFF,  16'd5,   1'b1, 0};
        vecs[6] = '{16'd9,     16'd3,      16'd3,     16'd0,   1'b0, 16};
        vecs[7] = '{16'd1000,  16'd33,     16'd30,    16'd10,  1'b0, 16};
        vecs[8] = '{16'd65535, 16'd256,    16'd255,   16'd255, 1'b0, 16};
        vecs[9] = '{16'd12345, 16'd123,    16'd100,   16'd45,  1'b0, 16};

        // Reset state, observed before any clock edge.
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].dvd, vecs[i].dvs);
            wait_done(lat, busy_ok);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), {31'd0, busy_ok}, 32'd1);
            check($sformatf("v%0d_q", i), {16'd0, quotient}, {16'd0, vecs[i].q});
            check($sformatf("v%0d_r", i), {16'd0, remainder}, {16'd0, vecs[i].r});
            check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            check_pulse(vecs[i].q, vecs[i].r);
        end

        // Start while busy is ignored: 200/9 runs, 50/5 arrives at RUN step 5.
        issue(16'd200, 16'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        issue(16'd50, 16'd5);
        wait_done(lat, busy_ok);
        // Five of the sixteen steps already elapsed before this wait.
        check("ign_lat", lat, 11);
        check("ign_q", {16'd0, quotient}, 32'd22);
        check("ign_r", {16'd0, remainder}, 32'd2);

        // Start in the DONE cycle is accepted back-to-back.
        issue(16'd100, 16'd10);
        wait_done(lat, busy_ok);
        check("b2b_lat", lat, 16);
        check("b2b_busy", {31'd0, busy_ok}, 32'd1);
        check("b2b_q", {16'd0, quotient}, 32'd10);
        check("b2b_r", {16'd0, remainder}, 32'd0);
        check_pulse(16'd10, 16'd0);

        // Asynchronous reset in the middle of RUN.
        issue(16'd200, 16'd9);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_q", {16'd0, quotient}, 32'd0);
        check("arst_r", {16'd0, remainder}, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        issue(16'd1000, 16'd33);
        wait_done(lat, busy_ok);
        check("after_rst_lat", lat, 16);
        check("after_rst_q", {16'd0, quotient}, 32'd30);
        check("after_rst_r", {16'd0, remainder}, 32'd10);
        check_pulse(16'd30, 16'd10);

        // Random operands checked against integer division.
        for (int n = 0; n < 300; n++) begin
            rd = 16'($urandom);
            rs = (n % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (rs == 16'd0) begin
                eq = 16'hFFFF;
                er = rd;
            end else begin
                eq = rd / rs;
                er = rd % rs;
            end
            issue(rd, rs);
            wait_done(lat, busy_ok);
            check("rnd_lat", lat, (rs == 16'd0) ? 0 : 16);
            check("rnd_q", {16'd0, quotient}, {16'd0, eq});
            check("rnd_r", {16'd0, remainder}, {16'd0, er});
            check("rnd_dbz", {31'd0, div_by_zero}, {31'd0, (rs == 16'd0)});
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
